// File: rtl/instr_prefetch_queue_if.sv
// Bus between the instruction prefetch queue, the instruction RAM port and the IF/ID stage.
// The slave modport is the queue itself; the master modport is the surrounding pipeline.
interface instr_prefetch_queue_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              flush;
    logic [ADDR_W-1:0] flush_target;
    logic              IF_ID_Load;
    logic              out_valid;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc4;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    modport master (
        input  fetch_addr, out_valid, out_instr, out_pc4, count, full, empty,
        output fetch_data, flush, flush_target, IF_ID_Load
    );

    modport slave (
        input  fetch_data, flush, flush_target, IF_ID_Load,
        output fetch_addr, out_valid, out_instr, out_pc4, count, full, empty
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch buffer: owns the fetch PC, fills a circular queue from a
// combinational instruction RAM and presents the oldest word plus its PC+4 to IF/ID.
module instr_prefetch_queue #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 4,
    parameter int                PC_STEP   = 4,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
    input logic                   clk,
    input logic                   Reset,
    instr_prefetch_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] fetch_pc;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;

    logic [DATA_W-1:0] mem_instr [DEPTH];
    logic [ADDR_W-1:0] mem_pc4   [DEPTH];

    logic              full_q;
    logic              empty_q;
    logic              pop;
    logic              push;
    logic [ADDR_W-1:0] next_pc;

    assign full_q  = (count_q == CNT_W'(DEPTH));
    assign empty_q = (count_q == '0);
    assign next_pc = fetch_pc + ADDR_W'(PC_STEP);

    // Flush wins over both sides; a full queue may still push when it pops in the same cycle.
    assign pop  = !empty_q && bus.IF_ID_Load && !bus.flush;
    assign push = !bus.flush && (!full_q || pop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            fetch_pc <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
        end else if (bus.flush) begin
            fetch_pc <= bus.flush_target;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fetch_pc <= next_pc;
                wr_ptr   <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: entry storage has no reset; validity is tracked by count_q, so stale data is never shown.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= bus.fetch_data;
            mem_pc4[wr_ptr]   <= next_pc;
        end
    end

    // Outputs come only from registered state: no input-to-output combinational path.
    assign bus.fetch_addr = fetch_pc;
    assign bus.count      = count_q;
    assign bus.full       = full_q;
    assign bus.empty      = empty_q;
    assign bus.out_valid  = !empty_q;
    assign bus.out_instr  = empty_q ? NOP_INSTR : mem_instr[rd_ptr];
    assign bus.out_pc4    = empty_q ? '0 : mem_pc4[rd_ptr];
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: RAM model returns (addr/4)+100, every
// expected value below is worked out by hand from that model.
module tb_instr_prefetch_queue;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic Reset;

    int vectors     = 0;
    int miscompares = 0;

    instr_prefetch_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    instr_prefetch_queue #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .PC_STEP(4), .NOP_INSTR('0)
    ) dut (
        .clk  (clk),
        .Reset(Reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [31:0] addr);
        return (addr >> 2) + 32'd100;
    endfunction

    assign bus.fetch_data = ram_word(bus.fetch_addr);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] instr, input logic [31:0] pc4);
        check({tag, "_instr"}, 64'(bus.out_instr), 64'(instr));
        check({tag, "_pc4"},   64'(bus.out_pc4),   64'(pc4));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_empty"}, 64'(bus.empty),      64'd1);
        check({tag, "_full"},  64'(bus.full),       64'd0);
        check({tag, "_valid"}, 64'(bus.out_valid),  64'd0);
        check({tag, "_count"}, 64'(bus.count),      64'd0);
        check({tag, "_faddr"}, 64'(bus.fetch_addr), 64'd0);
        check_head(tag, 32'd0, 32'd0);
    endtask

    initial begin
        int exp_idx;
        int popped;
        int budget;

        Reset            = 1'b1;
        bus.flush        = 1'b0;
        bus.flush_target = '0;
        bus.IF_ID_Load   = 1'b1;
        #2;
        check_reset_outputs("reset");
        Reset = 1'b0;

        // 1: streaming with IF_ID_Load held high.
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("t1_valid", 64'(bus.out_valid), 64'd1);
            check("t1_count", 64'(bus.count), 64'd1);
            check_head("t1", 32'(99 + k), 32'(4 * k));
        end

        // 2: stall until full, then a single pop with simultaneous push.
        Reset = 1'b1;
        #1;
        Reset          = 1'b0;
        bus.IF_ID_Load = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("t2_count", 64'(bus.count), 64'(k < 4 ? k : 4));
            check("t2_full", 64'(bus.full), 64'(k >= 4));
            check("t2_faddr", 64'(bus.fetch_addr), 64'(k < 4 ? 4 * k : 16));
        end
        check_head("t2_head", 32'd100, 32'd4);
        bus.IF_ID_Load = 1'b1;
        tick();
        check("t2_pp_count", 64'(bus.count), 64'd4);
        check("t2_pp_faddr", 64'(bus.fetch_addr), 64'd20);
        check_head("t2_pp", 32'd101, 32'd8);

        // 3: flush a full queue while IF_ID_Load is high.
        bus.flush        = 1'b1;
        bus.flush_target = 32'h40;
        tick();
        bus.flush      = 1'b0;
        bus.IF_ID_Load = 1'b0;
        check("t3_empty", 64'(bus.empty), 64'd1);
        check("t3_count", 64'(bus.count), 64'd0);
        check("t3_faddr", 64'(bus.fetch_addr), 64'h40);
        check_head("t3_nop", 32'd0, 32'd0);
        tick();
        check_head("t3_target", 32'd116, 32'h44);

        // 4: random stalls across pointer wraps, checked against fetch order.
        exp_idx = 16;
        popped  = 0;
        budget  = 200;
        while (popped < 3 * DEPTH + 1 && budget > 0) begin
            bus.IF_ID_Load = 1'($urandom_range(0, 1));
            if (bus.out_valid && bus.IF_ID_Load) begin
                check_head("t4_order", 32'(exp_idx + 100), 32'(4 * exp_idx + 4));
                exp_idx++;
                popped++;
            end
            tick();
            budget--;
        end
        check("t4_popped", 64'(popped), 64'(3 * DEPTH + 1));

        // 5: asynchronous reset mid-stream with three entries held.
        bus.IF_ID_Load   = 1'b0;
        bus.flush        = 1'b1;
        bus.flush_target = 32'h100;
        tick();
        bus.flush = 1'b0;
        repeat (3) tick();
        check("t5_count3", 64'(bus.count), 64'd3);
        #2;
        Reset = 1'b1;
        #1;
        check_reset_outputs("t5_async");
        #2;
        Reset = 1'b0;
        tick();
        check_head("t5_restart", 32'd100, 32'd4);
        check("t5_faddr", 64'(bus.fetch_addr), 64'd4);

        // 6: fetch PC wraps past the top of the address space.
        bus.flush        = 1'b1;
        bus.flush_target = 32'hFFFF_FFF8;
        tick();
        bus.flush = 1'b0;
        check("t6_faddr0", 64'(bus.fetch_addr), 64'hFFFF_FFF8);
        tick();
        check_head("t6_first", 32'h4000_0062, 32'hFFFF_FFFC);
        tick();
        check("t6_wrap", 64'(bus.fetch_addr), 64'd0);
        tick();
        check("t6_count", 64'(bus.count), 64'd3);
        bus.IF_ID_Load = 1'b1;
        tick();
        check_head("t6_last", 32'h4000_0063, 32'd0);
        tick();
        check_head("t6_zero", 32'd100, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
